// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encodings,
// opcode constants, ALU/PC select encodings and the control-vector struct.
// Used by the controller, the ALU decoder and the testbench.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        ADDIEX = 4'd11,
        ADDIWB = 4'd12,
        TRAP   = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B        = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       MemtoReg;
        logic       IRWrite;
        logic       RegWrite;
        logic       RegDst;
        logic       ALUSrcA;
        logic [1:0] PCSource;
        logic [1:0] ALUOp;
        logic [1:0] ALUSrcB;
        logic       pc_en;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bus: instruction fields and flags in, controls out.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
    logic       MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       pc_en;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
               MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA,
               PCSource, ALUOp, ALUSrcB, pc_en
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
               MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA,
               PCSource, ALUOp, ALUSrcB, pc_en
    );
endinterface

// File: rtl/mips_ctrl_decode.sv
// State -> control-vector decode. Only FETCH looks at mem_ready (IRWrite and
// PCWrite wait for the fetch to complete); pc_en folds in the ALU zero flag.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_e i_state,
    input  logic   i_mem_ready,
    input  logic   i_zero,
    output ctrl_t  o_ctrl
);

    // Moore decode with all-zero default; unlisted states (IDLE, TRAP, 14, 15) stay quiet
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            FETCH: begin
                o_ctrl.MemRead = 1'b1;
                o_ctrl.ALUSrcB = SRCB_FOUR;
                o_ctrl.IRWrite = i_mem_ready;
                o_ctrl.PCWrite = i_mem_ready;
            end
            DECODE: o_ctrl.ALUSrcB = SRCB_SEXT_SH2;
            MEMADR: begin
                o_ctrl.ALUSrcA = 1'b1;
                o_ctrl.ALUSrcB = SRCB_SEXT;
            end
            MEMRD: begin
                o_ctrl.MemRead = 1'b1;
                o_ctrl.IorD    = 1'b1;
            end
            MEMWB: begin
                o_ctrl.RegWrite = 1'b1;
                o_ctrl.MemtoReg = 1'b1;
            end
            MEMWR: begin
                o_ctrl.MemWrite = 1'b1;
                o_ctrl.IorD     = 1'b1;
            end
            EXEC: begin
                o_ctrl.ALUSrcA = 1'b1;
                o_ctrl.ALUOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                o_ctrl.RegWrite = 1'b1;
                o_ctrl.RegDst   = 1'b1;
            end
            BRANCH: begin
                o_ctrl.ALUSrcA     = 1'b1;
                o_ctrl.ALUOp       = ALUOP_SUB;
                o_ctrl.PCWriteCond = 1'b1;
                o_ctrl.PCSource    = PCSRC_ALUOUT;
            end
            JUMP: begin
                o_ctrl.PCWrite  = 1'b1;
                o_ctrl.PCSource = PCSRC_JUMP;
            end
            ADDIEX: begin
                o_ctrl.ALUSrcA = 1'b1;
                o_ctrl.ALUSrcB = SRCB_SEXT;
            end
            ADDIWB: o_ctrl.RegWrite = 1'b1;
            default: o_ctrl = '0;
        endcase
        o_ctrl.pc_en = o_ctrl.PCWrite | (o_ctrl.PCWriteCond & i_zero);
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory port and ALU, stalls on mem_ready, counts retirements.
// Optional macro MULTICYCLE_CTRL_TRAP_EN: undefined opcodes lock into TRAP and
// raise the sticky illegal flag; otherwise they drop back to FETCH uncounted.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 4
) (
    input  logic                 clk,
    input  logic                 Reset,
    mips_multicycle_ctrl_if.master bus,
    output logic [STATE_W-1:0]   state,
    output logic [CNT_W-1:0]     instr_count
`ifdef MULTICYCLE_CTRL_TRAP_EN
    ,
    output logic                 illegal
`endif
);

    state_e           r_state, w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_retire;
    ctrl_t            w_ctrl;

    // funct is consumed by the ALU decoder, not here
    wire w_unused_funct = &{1'b0, bus.funct};

    // State register; reset drops straight to IDLE so controls go quiet at once
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and retirement decode
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            IDLE:   w_next = FETCH;
            FETCH:  if (bus.mem_ready) w_next = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = EXEC;
                    OP_BEQ:       w_next = BRANCH;
                    OP_J:         w_next = JUMP;
                    OP_ADDI:      w_next = ADDIEX;
                    default: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                        w_next = TRAP;
`else
                        w_next = FETCH;
`endif
                    end
                endcase
            end
            MEMADR: w_next = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (bus.mem_ready) w_next = MEMWB;
            MEMWR: begin
                if (bus.mem_ready) begin
                    w_next   = FETCH;
                    w_retire = 1'b1;
                end
            end
            EXEC:   w_next = ALUWB;
            ADDIEX: w_next = ADDIWB;
            MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: begin
                w_next   = FETCH;
                w_retire = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            TRAP:   w_next = TRAP;
`endif
            default: w_next = FETCH;
        endcase
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset)        r_count <= '0;
        else if (w_retire) r_count <= r_count + CNT_W'(1);
    end

`ifdef MULTICYCLE_CTRL_TRAP_EN
    logic r_illegal;

    // Sticky illegal flag, set on entry to TRAP
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset)              r_illegal <= 1'b0;
        else if (w_next == TRAP) r_illegal <= 1'b1;
    end

    assign illegal = r_illegal;
`endif

    mips_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (bus.mem_ready),
        .i_zero      (bus.zero),
        .o_ctrl      (w_ctrl)
    );

    assign bus.PCWrite     = w_ctrl.PCWrite;
    assign bus.PCWriteCond = w_ctrl.PCWriteCond;
    assign bus.IorD        = w_ctrl.IorD;
    assign bus.MemRead     = w_ctrl.MemRead;
    assign bus.MemWrite    = w_ctrl.MemWrite;
    assign bus.MemtoReg    = w_ctrl.MemtoReg;
    assign bus.IRWrite     = w_ctrl.IRWrite;
    assign bus.RegWrite    = w_ctrl.RegWrite;
    assign bus.RegDst      = w_ctrl.RegDst;
    assign bus.ALUSrcA     = w_ctrl.ALUSrcA;
    assign bus.PCSource    = w_ctrl.PCSource;
    assign bus.ALUOp       = w_ctrl.ALUOp;
    assign bus.ALUSrcB     = w_ctrl.ALUSrcB;
    assign bus.pc_en       = w_ctrl.pc_en;

    assign state       = STATE_W'(r_state);
    assign instr_count = r_count;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: the stimulus process drives one
// cycle of inputs and pushes the hand-computed outputs for that cycle; the
// monitor pops and compares on each falling edge.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        Reset;
    logic [3:0]  state;
    logic [31:0] instr_count;
    logic        ill_w;

    mips_multicycle_ctrl_if bus();

`ifdef MULTICYCLE_CTRL_TRAP_EN
    mips_multicycle_ctrl dut (.clk(clk), .Reset(Reset), .bus(bus),
                              .state(state), .instr_count(instr_count), .illegal(ill_w));
`else
    mips_multicycle_ctrl dut (.clk(clk), .Reset(Reset), .bus(bus),
                              .state(state), .instr_count(instr_count));
    assign ill_w = 1'b0;
`endif

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegWrite,RegDst,ALUSrcA,
    //  PCSource[2],ALUOp[2],ALUSrcB[2],pc_en}
    localparam logic [16:0] C_ZERO    = '0;
    localparam logic [16:0] C_FETCH_R = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b01,1'b1};
    localparam logic [16:0] C_FETCH_N = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b01,1'b0};
    localparam logic [16:0] C_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b11,1'b0};
    localparam logic [16:0] C_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b10,1'b0};
    localparam logic [16:0] C_MEMRD   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] C_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] C_MEMWR   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] C_EXEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
    localparam logic [16:0] C_ALUWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] C_BR_T    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b01,2'b00,1'b1};
    localparam logic [16:0] C_BR_N    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b01,2'b00,1'b0};
    localparam logic [16:0] C_JUMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,1'b1};
    localparam logic [16:0] C_ADDIEX  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b10,1'b0};
    localparam logic [16:0] C_ADDIWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};

    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] ctl;
        logic [31:0] cnt;
        logic        ill;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt    = 0;

    wire [16:0] act_ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                           bus.MemtoReg, bus.IRWrite, bus.RegWrite, bus.RegDst, bus.ALUSrcA,
                           bus.PCSource, bus.ALUOp, bus.ALUSrcB, bus.pc_en};

    // Drive one cycle of inputs, record what the DUT must show this cycle, advance
    task automatic step(input logic [5:0] op, input logic mr, input logic z,
                        input logic [3:0] st, input logic [16:0] ctl,
                        input logic ill, input string tag);
        exp_t e;
        bus.opcode    = op;
        bus.mem_ready = mr;
        bus.zero      = z;
        e.st  = st;
        e.ctl = ctl;
        e.cnt = 32'(cnt);
        e.ill = ill;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare outputs against the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (state !== e.st) begin
                    errors++;
                    $display("FAIL %s state got %0d want %0d", e.tag, state, e.st);
                end
                checks++;
                if (act_ctl !== e.ctl) begin
                    errors++;
                    $display("FAIL %s ctrl got %b want %b", e.tag, act_ctl, e.ctl);
                end
                checks++;
                if (instr_count !== e.cnt) begin
                    errors++;
                    $display("FAIL %s count got %0d want %0d", e.tag, instr_count, e.cnt);
                end
`ifdef MULTICYCLE_CTRL_TRAP_EN
                checks++;
                if (ill_w !== e.ill) begin
                    errors++;
                    $display("FAIL %s illegal got %b want %b", e.tag, ill_w, e.ill);
                end
`endif
            end
        end
    end

    initial begin
        bus.funct = 6'b100000;
        Reset = 1'b0;
        bus.opcode = OP_RTYPE; bus.mem_ready = 1'b1; bus.zero = 1'b0;
        @(posedge clk); #1;
        // held in reset with mem_ready high: everything quiet
        for (int i = 0; i < 9; i++) step(OP_RTYPE, 1, 1, IDLE, C_ZERO, 0, "reset");
        Reset = 1'b1;
        step(OP_RTYPE, 1, 1, IDLE, C_ZERO, 0, "rel");

        // R-type
        step(OP_RTYPE, 1, 0, FETCH,  C_FETCH_R, 0, "r_fetch");
        step(OP_RTYPE, 1, 0, DECODE, C_DECODE,  0, "r_dec");
        step(OP_RTYPE, 1, 0, EXEC,   C_EXEC,    0, "r_exec");
        step(OP_RTYPE, 1, 0, ALUWB,  C_ALUWB,   0, "r_wb");
        cnt = 1;

        // lw with stalls: FETCH 3 waits, MEMRD 2 waits -> 10 cycles
        for (int i = 0; i < 3; i++) step(OP_LW, 0, 0, FETCH, C_FETCH_N, 0, "lw_fwait");
        step(OP_LW, 1, 0, FETCH,  C_FETCH_R, 0, "lw_fetch");
        step(OP_LW, 1, 0, DECODE, C_DECODE,  0, "lw_dec");
        step(OP_LW, 0, 0, MEMADR, C_MEMADR,  0, "lw_adr");
        for (int i = 0; i < 2; i++) step(OP_LW, 0, 0, MEMRD, C_MEMRD, 0, "lw_rwait");
        step(OP_LW, 1, 0, MEMRD,  C_MEMRD,   0, "lw_rd");
        step(OP_LW, 1, 0, MEMWB,  C_MEMWB,   0, "lw_wb");
        cnt = 2;

        // beq taken then not taken; both retire
        step(OP_BEQ, 1, 0, FETCH,  C_FETCH_R, 0, "beqt_fetch");
        step(OP_BEQ, 1, 0, DECODE, C_DECODE,  0, "beqt_dec");
        step(OP_BEQ, 1, 1, BRANCH, C_BR_T,    0, "beqt_br");
        cnt = 3;
        step(OP_BEQ, 1, 0, FETCH,  C_FETCH_R, 0, "beqn_fetch");
        step(OP_BEQ, 1, 0, DECODE, C_DECODE,  0, "beqn_dec");
        step(OP_BEQ, 1, 0, BRANCH, C_BR_N,    0, "beqn_br");
        cnt = 4;

        // j
        step(OP_J, 1, 0, FETCH,  C_FETCH_R, 0, "j_fetch");
        step(OP_J, 1, 0, DECODE, C_DECODE,  0, "j_dec");
        step(OP_J, 0, 0, JUMP,   C_JUMP,    0, "j_jump");
        cnt = 5;

        // addi, mem_ready toggled where it must be ignored
        step(OP_ADDI, 1, 0, FETCH,  C_FETCH_R, 0, "addi_fetch");
        step(OP_ADDI, 0, 0, DECODE, C_DECODE,  0, "addi_dec");
        step(OP_ADDI, 0, 0, ADDIEX, C_ADDIEX,  0, "addi_ex");
        step(OP_ADDI, 1, 0, ADDIWB, C_ADDIWB,  0, "addi_wb");
        cnt = 6;

        // sw, completes immediately
        step(OP_SW, 1, 0, FETCH,  C_FETCH_R, 0, "sw_fetch");
        step(OP_SW, 1, 0, DECODE, C_DECODE,  0, "sw_dec");
        step(OP_SW, 1, 0, MEMADR, C_MEMADR,  0, "sw_adr");
        step(OP_SW, 1, 0, MEMWR,  C_MEMWR,   0, "sw_wr");
        cnt = 7;

        // undefined opcode
        step(OP_BAD, 1, 0, FETCH,  C_FETCH_R, 0, "bad_fetch");
        step(OP_BAD, 1, 0, DECODE, C_DECODE,  0, "bad_dec");
`ifdef MULTICYCLE_CTRL_TRAP_EN
        for (int i = 0; i < 20; i++) step(OP_RTYPE, 1, 1, TRAP, C_ZERO, 1, "trap");
        Reset = 1'b0;
        cnt = 0;
        step(OP_RTYPE, 1, 0, IDLE, C_ZERO, 0, "trap_rst");
        Reset = 1'b1;
        step(OP_RTYPE, 1, 0, IDLE, C_ZERO, 0, "trap_rel");
`endif

        // sw stalled in MEMWR, then reset pulse mid-access
        step(OP_SW, 1, 0, FETCH,  C_FETCH_R, 0, "swr_fetch");
        step(OP_SW, 1, 0, DECODE, C_DECODE,  0, "swr_dec");
        step(OP_SW, 0, 0, MEMADR, C_MEMADR,  0, "swr_adr");
        step(OP_SW, 0, 0, MEMWR,  C_MEMWR,   0, "swr_wait");
        Reset = 1'b0;
        cnt = 0;
        step(OP_SW, 0, 0, IDLE,   C_ZERO,    0, "swr_rst");
        Reset = 1'b1;
        step(OP_SW, 1, 0, IDLE,   C_ZERO,    0, "swr_rel");
        step(OP_SW, 1, 0, FETCH,  C_FETCH_R, 0, "swr_refetch");
        step(OP_SW, 1, 0, DECODE, C_DECODE,  0, "swr_redec");

        // let the monitor drain, bounded
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
